// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller:
// state encodings, default operand width and counter sizing.
package mult_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Handshake and strobe bundle between the multiplier controller and
// the product/multiplier shift-register datapath.
interface mult_ctrl_if;

    logic start;
    logic lsb;
    logic load;
    logic clr;
    logic add;
    logic shift;
    logic busy;
    logic done;

    modport master (
        output start, lsb,
        input  load, clr, add, shift, busy, done
    );

    modport slave (
        input  start, lsb,
        output load, clr, add, shift, busy, done
    );

endinterface

// File: rtl/mult_ctrl_cnt.sv
// Loadable iteration down-counter; flags the final iteration so the
// controller can leave the add/shift loop.
module mult_ctrl_cnt
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic is_one
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_INIT;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign is_one = (cnt == CNT_ONE);

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for a shift-add multiplier: Load/Clr, then WIDTH Add/Shift
// iterations, then a one-cycle Done pulse.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mult_ctrl_if.slave   bus
);

    state_t state;
    state_t next_state;
    logic   cnt_one;

    mult_ctrl_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (state == S_LOAD),
        .dec    (state == S_SHIFT),
        .is_one (cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ADD always takes a cycle, even when the multiplier bit is zero,
    // so the latency never depends on the operands.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.start) next_state = S_LOAD;
            S_LOAD:  next_state = S_ADD;
            S_ADD:   next_state = S_SHIFT;
            S_SHIFT: next_state = cnt_one ? S_DONE : S_ADD;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Everything is Moore except add, which follows lsb within ADD.
    always_comb begin
        bus.load  = 1'b0;
        bus.clr   = 1'b0;
        bus.add   = 1'b0;
        bus.shift = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_LOAD: begin
                bus.load = 1'b1;
                bus.clr  = 1'b1;
                bus.busy = 1'b1;
            end
            S_ADD: begin
                bus.add  = bus.lsb;
                bus.busy = 1'b1;
            end
            S_SHIFT: begin
                bus.shift = 1'b1;
                bus.busy  = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural shift-add datapath closes the loop
// on lsb, and a scoreboard holds product, add count and timing per run.
module tb_mult_ctrl;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 1;   // load-visible cycle to done-visible cycle
    localparam int GAP = 2 * W + 3;   // start sample to next start sample

    typedef struct {
        logic [15:0] prod;
        int          adds;
        int          load_c;
        int          done_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    mult_ctrl_if bus();

    mult_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        got_e;
    int          cyc     = 0;
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          add_cnt = 0;
    logic [7:0]  a_op    = '0;
    logic [7:0]  b_op    = '0;
    logic [7:0]  a_lat   = '0;
    logic [16:0] p       = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Datapath: 9-bit sum (with carry) into the upper half, then shift right.
    always @(posedge clk) begin
        if (bus.load) begin
            p     <= {bus.clr ? 9'd0 : p[16:8], b_op};
            a_lat <= a_op;
        end else if (bus.add) begin
            p[16:8] <= {1'b0, p[15:8]} + {1'b0, a_lat};
        end else if (bus.shift) begin
            p <= {1'b0, p[16:1]};
        end
    end

    assign bus.lsb = p[0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] b, input int load_c);
        exp_t e;
        e.prod   = 16'(a) * 16'(b);
        e.adds   = $countones(b);
        e.load_c = load_c;
        e.done_c = load_c + LAT;
        return e;
    endfunction

    initial forever begin
        @(negedge clk);
        check_val("excl", 32'($onehot0({bus.load, bus.add, bus.shift})), 32'd1);
        check_val("clr_load", 32'(bus.clr), 32'(bus.load));
        if (bus.add) add_cnt++;
        if (bus.load) begin
            add_cnt = 0;
            check_val("load_busy", 32'(bus.busy), 32'd1);
            if (sb.size() == 0) check_val("spurious_load", 32'(bus.load), 32'd0);
            else                check_val("load_cyc", 32'(cyc), 32'(sb[0].load_c));
        end
        if (bus.done) begin
            check_val("done_busy", 32'(bus.busy), 32'd0);
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                got_e = sb.pop_front();
                check_val("done_cyc", 32'(cyc), 32'(got_e.done_c));
                check_val("product", 32'(p[15:0]), 32'(got_e.prod));
                check_val("add_count", 32'(add_cnt), 32'(got_e.adds));
            end
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a_op      = a;
        b_op      = b;
        bus.start = 1'b1;
        sb.push_back(mk_exp(a, b, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty(input int max_cyc);
        int i = 0;
        while (sb.size() != 0 && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check_val("timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b1;

        // Reset dominates a held start.
        repeat (3) @(negedge clk);
        #1 check_val("rst_outs", 32'({bus.load, bus.clr, bus.add, bus.shift, bus.busy, bus.done}), 32'd0);

        // Release with start held: load one cycle later, 13 x 11.
        a_op = 8'd13;
        b_op = 8'd11;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(mk_exp(8'd13, 8'd11, cyc + 1));
        @(negedge clk);
        check_val("rst_rel_load", 32'(bus.load), 32'd1);
        bus.start = 1'b0;
        wait_empty(40);

        // Operand extremes and an arbitrary pair.
        start_op(8'd0, 8'd255);
        wait_empty(40);
        start_op(8'd255, 8'd255);
        wait_empty(40);
        start_op(8'd200, 8'd37);
        wait_empty(40);

        // Start pulses while busy and during DONE must be dropped.
        start_op(8'd13, 8'd11);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        check_val("done_at_k18", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        check_val("no_requeue", 32'(sb.size()), 32'd0);

        // Abort in the 4th SHIFT, then a clean rerun.
        start_op(8'd77, 8'd201);
        repeat (8) @(negedge clk);
        check_val("pre_rst_shift", 32'(bus.shift), 32'd1);
        rst = 1'b1;
        #1 check_val("abort_outs", 32'({bus.load, bus.clr, bus.add, bus.shift, bus.busy, bus.done}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        start_op(8'd77, 8'd201);
        wait_empty(40);

        // Start held for three back-to-back operations.
        @(negedge clk);
        a_op      = 8'd3;
        b_op      = 8'd5;
        bus.start = 1'b1;
        sb.push_back(mk_exp(8'd3,   8'd5,   cyc + 1));
        sb.push_back(mk_exp(8'd128, 8'd255, cyc + 1 + GAP));
        sb.push_back(mk_exp(8'd99,  8'd170, cyc + 1 + 2 * GAP));
        repeat (3) @(negedge clk);
        a_op = 8'd128;
        b_op = 8'd255;
        repeat (GAP) @(negedge clk);
        a_op = 8'd99;
        b_op = 8'd170;
        repeat (GAP) @(negedge clk);
        bus.start = 1'b0;
        wait_empty(60);
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Control unit for the sequential shift-add multiplier. Sits beside the product/multiplier shift register and generates its Load, Add and Shift strobes from a Start/Done handshake. It samples the register's LSB output to decide, per multiplier bit, whether the adder result is written back. It runs a fixed-latency sequence of WIDTH add/shift iterations, then pulses Done.

## Interface
- WIDTH, 8: multiplier operand width; sets the iteration count (must be ≥1).
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  begin a multiplication; sampled only in IDLE.
- LSB  in  1  current bit 0 of the product/multiplier register.
- Load  out  1  one-cycle strobe: product register captures multiplier operand into low half.
- Clr  out  1  high in the same cycle as Load: datapath clears product upper half / adder carry.
- Add  out  1  write adder sum into product upper half (9 bits incl. carry).
- Shift  out  1  shift product register right by one.
- Busy  out  1  high from LOAD through the last SHIFT.
- Done  out  1  one-cycle pulse: product valid on the register's 16-bit output.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. Encoding is binary, 3 bits.
- IDLE: all strobes 0. Start=1 → LOAD; otherwise stay.
- LOAD: Load=1, Clr=1, Busy=1. Iteration counter cnt ← WIDTH. → ADD.
- ADD: Busy=1. Add = LSB, a Mealy output decoded combinationally from LSB. → SHIFT unconditionally. The state occupies a cycle even when LSB=0.
- SHIFT: Shift=1, Busy=1, cnt ← cnt−1. If cnt==1 before the decrement → DONE; else → ADD.
- DONE: Done=1, Busy=0. → IDLE unconditionally. Start is ignored here.
- Load, Add and Shift are mutually exclusive in every cycle; a bench assertion checks this.
- cnt width: $clog2(WIDTH+1). cnt never wraps: the decrement occurs only in SHIFT, with cnt≥1.
- Start asserted while Busy or in DONE is ignored. It is not queued.
- Start held high continuously: a new multiplication begins on the edge after DONE→IDLE. Back-to-back operations are separated by exactly one IDLE cycle.
- LSB is read only in ADD; its value in other states has no effect.

## Timing
- Reset values: state=IDLE, cnt=0, Load=Clr=Add=Shift=Busy=Done=0.
- Rst asserted at any point, including mid-sequence, forces IDLE immediately without waiting for a clock. No Done is produced for the aborted operation.
- Rst deassertion is synchronised externally. The first Start is sampled on the first rising edge after release.
- Start sampled high on edge k, in IDLE:
  - LOAD during cycle k+1.
  - ADD/SHIFT pairs occupy cycles k+2 … k+2·WIDTH+1.
  - DONE is in cycle k+2·WIDTH+2 (k+18 for WIDTH=8).
  - IDLE is in cycle k+2·WIDTH+3.
- Latency is fixed at 2·WIDTH+2 cycles from the Start sample to Done, independent of operand values.
- All outputs except Add are Moore, decoded from state. Add has a combinational path LSB→Add of one gate.

## Structure
- Shared header mult_pkg: state encodings (S_IDLE=0, S_LOAD=1, S_ADD=2, S_SHIFT=3, S_DONE=4), default WIDTH, CNT_W macro.
- One sub-module: mult_cnt, a loadable down-counter with a zero/one-detect output.
- State register and output decode live in mult_ctrl.

## Test plan
- Reset: Rst=1 with Start=1 → all outputs 0. Release Rst, hold Start=1 → Load=1 exactly one cycle later.
- Integrated with the datapath, 13×11 → Done in cycle 18 after the Start sample; product output = 16'd143; Add asserted 3 times, matching the multiplier bits of 11=1011b.
- Edge operands: 0×255 → Add never high, product 0. 255×255 → Add high in all 8 ADD cycles, product 16'd65025.
- Start pulsed during cycle 6 of a busy run and during DONE → ignored; exactly one Done; the next Load occurs only after a fresh Start in IDLE.
- Rst asserted mid-run, in the 4th SHIFT cycle → outputs 0 within the same cycle, no Done. A new Start → full 18-cycle sequence with the correct product.
- Start held high for 3 operations → Done pulses spaced 2·WIDTH+3 = 19 cycles apart; Load/Add/Shift never overlap.
